div_rep_sub: RTL and testbench



---
 rtl/div_rep_sub.sv | 53 +++++
 tb/tb_div_rep_sub.sv | 135 +++++++++++++
 2 files changed

// File: rtl/div_rep_sub.sv
// div_rep_sub: unsigned divider by repeated subtraction with start/done handshake
// Ports: clk, rst_n (async active-low); start, dividend, divisor (request, sampled in IDLE);
//        quotient, remainder, dz (results, valid with done); busy (not IDLE), done (one-cycle pulse)
module div_rep_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz
);
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_rem, r_quot, r_dvsr;
  logic             r_dz;
  logic             w_ge, w_zero;
  assign w_ge   = r_rem >= r_dvsr;
  assign w_zero = divisor == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)     w_next = start ? (w_zero ? DONE : SUB) : IDLE;
    else if (r_state == SUB) w_next = w_ge ? SUB : DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvsr <= '0;
      r_dz   <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_rem  <= dividend;
      r_dvsr <= divisor;
      r_quot <= w_zero ? '1 : '0;
      r_dz   <= w_zero;
    end else if (r_state == SUB && w_ge) begin
      r_rem  <= r_rem - r_dvsr;
      r_quot <= r_quot + 1'b1;
    end
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign dz        = r_dz;
  assign busy      = r_state != IDLE;
  assign done      = r_state == DONE;
endmodule

// File: tb/tb_div_rep_sub.sv
// tb_div_rep_sub: directed table-driven bench for div_rep_sub
module tb_div_rep_sub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic [15:0] quotient, remainder;
  logic        busy, done, dz;
  int          tests = 0, fails = 0;
  typedef struct {
    logic [15:0] a, b, q, r;
    logic        z;
    int          e;
  } vec_t;
  vec_t vec [10];
  div_rep_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done), .dz(dz)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 70000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic run_op(input vec_t v);
    int n;
    dividend = v.a;
    divisor  = v.b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_E0", busy, 1);
    wait_done(n);
    chk("done_edges", n, v.e);
    chk("quotient", quotient, v.q);
    chk("remainder", remainder, v.r);
    chk("dz", dz, v.z);
    @(posedge clk);
    #1;
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("quotient_hold", quotient, v.q);
  endtask
  initial begin
    int n;
    vec[0] = '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0, 15};
    vec[1] = '{16'd5,     16'd9,     16'd0,     16'd5,    1'b0, 1};
    vec[2] = '{16'd9,     16'd9,     16'd1,     16'd0,    1'b0, 2};
    vec[3] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1, 0};
    vec[4] = '{16'd10,    16'd3,     16'd3,     16'd1,    1'b0, 4};
    vec[5] = '{16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0, 65536};
    vec[6] = '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0, 1};
    vec[7] = '{16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0, 2};
    vec[8] = '{16'd7,     16'd2,     16'd3,     16'd1,    1'b0, 4};
    vec[9] = '{16'd20,    16'd6,     16'd3,     16'd2,    1'b0, 4};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) run_op(vec[i]);
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; ) begin
      start    = (k == 2 || k == 14);
      dividend = start ? 16'd50 : 16'd100;
      divisor  = start ? 16'd5 : 16'd7;
      @(posedge clk);
      k++;
      #1;
      if (k == 3) chk("ign_start_sub_done", done, 0);
      if (k == 15) begin
        chk("ign_done_edge15", done, 1);
        chk("ign_quotient", quotient, 14);
        chk("ign_remainder", remainder, 2);
      end
      if (k == 16) begin
        chk("ign_busy_low", busy, 0);
        chk("ign_quotient_hold", quotient, 14);
        chk("ign_remainder_hold", remainder, 2);
      end
    end
    run_op('{16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 11});
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_dz", dz, 0);
    n = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      n += done;
    end
    chk("arst_no_done", n, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_still_idle", busy, 0);
    run_op(vec[9]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
